// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and flag bundle for the multi-cycle ALU.
package alu_pkg;

   localparam logic [2:0] OP_OR  = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_AND = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles.
// product_o carries the final sum combinationally in the cycle done_o is high,
// so the caller can register it on the same edge the last step completes.
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [2*WIDTH-1:0]   product_o
);
   import alu_pkg::*;

   localparam int CW = $clog2(WIDTH);

   logic                 busy_q,   busy_d;
   logic [CW-1:0]        cnt_q,    cnt_d;
   logic [2*WIDTH-1:0]   acc_q,    acc_d;
   logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic                 last;

   assign last      = busy_q && (cnt_q == CW'(WIDTH - 1));
   assign busy_o    = busy_q;
   assign done_o    = last;
   assign product_o = acc_d;

   // Next-state for the shift-add datapath: load on start, one step per busy cycle.
   always_comb begin
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      if (start_i) begin
         busy_d   = 1'b1;
         cnt_d    = '0;
         acc_d    = '0;
         mcand_d  = {{WIDTH{1'b0}}, a_i};
         mplier_d = b_i;
      end else if (busy_q) begin
         acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CW'(1);
         if (last) busy_d = 1'b0;
      end
   end

   // Datapath registers; reset aborts any multiply in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Registered ALU with valid/ready on both sides. Single-cycle ops retire one
// cycle after accept; MUL runs through alu_mul_iter and blocks new issue.
module alu_mc #(
   parameter int WIDTH      = 32,
   parameter bit SLT_SIGNED = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         sel,
   input  logic [WIDTH-1:0]   op1,
   input  logic [WIDTH-1:0]   op2,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   Result,
   output logic               zflag,
   output logic               nflag,
   output logic               cflag,
   output logic               vflag
);
   import alu_pkg::*;

   localparam int SW = $clog2(WIDTH);
   localparam int M  = WIDTH - 1;

   state_e               state_q, state_d;
   logic                 valid_q, valid_d;
   logic [WIDTH-1:0]     res_q,   res_d;
   flags_t               flg_q,   flg_d;

   logic                 accept, is_mul, mul_start;
   logic                 mul_busy, mul_done;
   logic [2*WIDTH-1:0]   mul_prod;

   logic [WIDTH:0]       sum, diff;
   logic                 lt;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_c, alu_v;

   // Accept only when idle and the output slot is free or draining this cycle.
   assign in_ready  = rst_n && (state_q == ST_IDLE) && !mul_busy && (!valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign is_mul    = (sel == OP_MUL);
   assign mul_start = accept && is_mul;

   assign out_valid = valid_q;
   assign Result    = res_q;
   assign zflag     = flg_q.z;
   assign nflag     = flg_q.n;
   assign cflag     = flg_q.c;
   assign vflag     = flg_q.v;

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (mul_start),
      .a_i       (op1),
      .b_i       (op2),
      .busy_o    (mul_busy),
      .done_o    (mul_done),
      .product_o (mul_prod)
   );

   // Adder/subtractor one bit wider so carry and borrow fall out of the MSB.
   assign sum  = {1'b0, op1} + {1'b0, op2};
   assign diff = {1'b0, op1} - {1'b0, op2};

   // SLT flavour fixed at elaboration.
   always_comb begin
      if (SLT_SIGNED) lt = ($signed(op1) < $signed(op2));
      else            lt = (op1 < op2);
   end

   // Single-cycle result and arithmetic flags for the presented opcode.
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (sel)
         OP_OR:  alu_res = op1 | op2;
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (op1[M] == op2[M]) && (sum[M] != op1[M]);
         end
         OP_XOR: alu_res = op1 ^ op2;
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
            alu_v   = (op1[M] != op2[M]) && (diff[M] != op1[M]);
         end
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, lt};
         OP_SHL: alu_res = op2 << op1[SW-1:0];
         OP_AND: alu_res = op1 & op2;
         default: alu_res = '0;
      endcase
   end

   // FSM next state: MUL accept enters BUSY, multiplier's last step returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (mul_start) state_d = ST_BUSY;
         ST_BUSY: if (mul_done)  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output slot: load on MUL completion or single-cycle accept, else drain or hold.
   always_comb begin
      valid_d = valid_q;
      res_d   = res_q;
      flg_d   = flg_q;
      if (mul_done) begin
         valid_d = 1'b1;
         res_d   = mul_prod[WIDTH-1:0];
         flg_d.z = (mul_prod[WIDTH-1:0] == '0);
         flg_d.n = mul_prod[WIDTH-1];
         flg_d.c = |mul_prod[2*WIDTH-1:WIDTH];
         flg_d.v = 1'b0;
      end else if (accept && !is_mul) begin
         valid_d = 1'b1;
         res_d   = alu_res;
         flg_d.z = (alu_res == '0);
         flg_d.n = alu_res[WIDTH-1];
         flg_d.c = alu_c;
         flg_d.v = alu_v;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         res_q   <= '0;
         flg_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         res_q   <= res_d;
         flg_q   <= flg_d;
      end
   end

endmodule
